// File: rtl/pre_decode_pkg.sv
// pre_decode_pkg: shared bus widths, field layouts and constants for the pre-decode stage
package pre_decode_pkg;
  localparam int FPD_BUS_WID = 43;
  localparam int PDD_BUS_WID = 74;
  localparam int ECODE_WID = 8;
  localparam int ESUB_WID = 1;
  localparam logic [31:0] NOP_INST_DEF = 32'h0340_0000;
  localparam logic [ECODE_WID-1:0] ECODE_ADEF = 8'h08;
  typedef struct packed {
    logic [31:0] pc;
    logic pc_en;
    logic ex;
    logic [ECODE_WID-1:0] ecode;
    logic [ESUB_WID-1:0] esub;
  } fpd_bus_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic ex;
    logic [ECODE_WID-1:0] ecode;
    logic [ESUB_WID-1:0] esub;
  } pdd_bus_t;
endpackage

// File: rtl/inst_skid_buf.sv
// inst_skid_buf: one-entry 32-bit instruction hold (clk, rst, capture, clear, din -> dout, valid); clear wins over capture
module inst_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        valid
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (capture) begin
      dout <= din;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/pre_decode.sv
// pre_decode: pairs Fetch bundle (FpD_valid/FpD_BUS) with next-cycle inst_sram_rdata, skid-buffers it across Decode stalls (D_allowin, flush) and drives pDD_valid/pDD_BUS plus pD_allowin
module pre_decode
  import pre_decode_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   FpD_valid,
  input  logic [FPD_BUS_WID-1:0] FpD_BUS,
  input  logic [31:0]            inst_sram_rdata,
  input  logic                   flush,
  input  logic                   D_allowin,
  output logic                   pD_allowin,
  output logic                   pDD_valid,
  output logic [PDD_BUS_WID-1:0] pDD_BUS
);
  fpd_bus_t fb;
  pdd_bus_t ob;
  logic pd_valid, first_q, ex_q, accept, buf_valid, capture;
  logic [31:0] pc_q, inst_buf;
  logic [ECODE_WID-1:0] ecode_q;
  logic [ESUB_WID-1:0] esub_q;
  assign fb = FpD_BUS;
  assign pD_allowin = !pd_valid || D_allowin || flush;
  assign accept = FpD_valid && fb.pc_en && pD_allowin;
  assign capture = first_q && pd_valid && !D_allowin && !flush;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pd_valid <= 1'b0;
      first_q <= 1'b0;
      pc_q <= '0;
      ex_q <= 1'b0;
      ecode_q <= '0;
      esub_q <= '0;
    end else begin
      first_q <= accept;
      if (accept) begin
        pd_valid <= 1'b1;
        pc_q <= fb.pc;
        ex_q <= fb.ex;
        ecode_q <= fb.ecode;
        esub_q <= fb.esub;
      end else if (D_allowin || flush) begin
        pd_valid <= 1'b0;
      end
    end
  end
  inst_skid_buf u_skid (
    .clk(clk),
    .rst(rst),
    .capture(capture),
    .clear(accept || flush),
    .din(inst_sram_rdata),
    .dout(inst_buf),
    .valid(buf_valid)
  );
  always_comb begin
    ob.pc = pc_q;
    ob.inst = ex_q ? NOP_INST : (buf_valid ? inst_buf : inst_sram_rdata);
    ob.ex = ex_q;
    ob.ecode = ecode_q;
    ob.esub = esub_q;
  end
  assign pDD_valid = pd_valid && !flush;
  assign pDD_BUS = ob;
endmodule

// File: tb/tb_pre_decode.sv
// tb_pre_decode: directed vector table, hand-written reset corner case and scoreboarded random streaming for pre_decode
module tb_pre_decode;
  import pre_decode_pkg::*;
  logic clk = 1'b0, rst = 1'b1, FpD_valid = 1'b0, flush = 1'b0, D_allowin = 1'b0;
  logic [42:0] FpD_BUS = '0;
  logic [31:0] inst_sram_rdata = '0;
  logic pD_allowin, pDD_valid;
  logic [73:0] pDD_BUS;
  int pass_cnt = 0, tot_cnt = 0;
  logic [73:0] sb[$];
  logic [31:0] pend_rd = '0, pc_ctr = 32'h1C00_1000;
  bit have_pend = 0;
  typedef struct {
    logic fv, pe, ex;
    logic [31:0] pc;
    logic [7:0] ecode;
    logic [31:0] rdata;
    logic fl, dal, ev, ea;
    logic [31:0] epc, einst;
    logic eex;
    logic [7:0] eecode;
  } vec_t;
  vec_t vecs[$];
  pre_decode dut (
    .clk(clk), .rst(rst), .FpD_valid(FpD_valid), .FpD_BUS(FpD_BUS),
    .inst_sram_rdata(inst_sram_rdata), .flush(flush), .D_allowin(D_allowin),
    .pD_allowin(pD_allowin), .pDD_valid(pDD_valid), .pDD_BUS(pDD_BUS)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int idx, input logic [73:0] act, input logic [73:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
  endtask
  task automatic drive(input logic fv, input logic pe, input logic ex, input logic [31:0] pc,
                       input logic [7:0] ec, input logic [31:0] rd, input logic fl, input logic dal);
    FpD_valid = fv;
    FpD_BUS = {pc, pe, ex, ec, 1'b0};
    inst_sram_rdata = rd;
    flush = fl;
    D_allowin = dal;
  endtask
  task automatic rcycle(input int n, input logic fv, input logic pe, input logic ex, input logic dal);
    logic occ;
    logic [31:0] rd;
    @(negedge clk);
    drive(fv, pe, ex, pc_ctr, ex ? ECODE_ADEF : 8'h00, have_pend ? pend_rd : $urandom, 1'b0, dal);
    have_pend = 0;
    #1;
    occ = sb.size() != 0;
    chk("r_valid", n, 74'(pDD_valid), 74'(occ));
    chk("r_allowin", n, 74'(pD_allowin), 74'(!occ || dal));
    if (occ) chk("r_bus", n, pDD_BUS, sb[0]);
    if (occ && dal) void'(sb.pop_front());
    if (fv && pe && (!occ || dal)) begin
      rd = $urandom;
      sb.push_back({pc_ctr, ex ? 32'h0340_0000 : rd, ex, ex ? 8'h08 : 8'h00, 1'b0});
      pend_rd = rd;
      have_pend = 1;
      pc_ctr += 4;
    end
  endtask
  initial begin
    vecs.push_back('{'0, '0, '0, '0, '0, '0, '0, '1, '0, '1, '0, '0, '0, '0});
    vecs.push_back('{'1, '1, '0, 32'h1C00_0000, '0, '0, '0, '1, '0, '1, '0, '0, '0, '0});
    vecs.push_back('{'1, '1, '0, 32'h1C00_0004, '0, 32'hA, '0, '1, '1, '1, 32'h1C00_0000, 32'hA, '0, '0});
    vecs.push_back('{'1, '1, '0, 32'h1C00_0008, '0, 32'hB, '0, '1, '1, '1, 32'h1C00_0004, 32'hB, '0, '0});
    vecs.push_back('{'0, '0, '0, '0, '0, 32'hC, '0, '1, '1, '1, 32'h1C00_0008, 32'hC, '0, '0});
    vecs.push_back('{'0, '0, '0, '0, '0, '0, '0, '1, '0, '1, '0, '0, '0, '0});
    vecs.push_back('{'1, '1, '0, 32'h1C00_0010, '0, '0, '0, '1, '0, '1, '0, '0, '0, '0});
    vecs.push_back('{'0, '0, '0, '0, '0, 32'h1234_5678, '0, '0, '1, '0, 32'h1C00_0010, 32'h1234_5678, '0, '0});
    vecs.push_back('{'1, '1, '0, 32'h1C00_0020, '0, 32'hDEAD_BEEF, '0, '0, '1, '0, 32'h1C00_0010, 32'h1234_5678, '0, '0});
    vecs.push_back('{'0, '0, '0, '0, '0, 32'hDEAD_BEEF, '0, '0, '1, '0, 32'h1C00_0010, 32'h1234_5678, '0, '0});
    vecs.push_back('{'0, '0, '0, '0, '0, 32'hDEAD_BEEF, '0, '1, '1, '1, 32'h1C00_0010, 32'h1234_5678, '0, '0});
    vecs.push_back('{'0, '0, '0, '0, '0, '0, '0, '1, '0, '1, '0, '0, '0, '0});
    vecs.push_back('{'1, '0, '0, 32'h1C00_0030, '0, '0, '0, '1, '0, '1, '0, '0, '0, '0});
    vecs.push_back('{'0, '0, '0, '0, '0, 32'h55, '0, '1, '0, '1, '0, '0, '0, '0});
    vecs.push_back('{'1, '1, '1, 32'h1C00_0002, 8'h08, '0, '0, '1, '0, '1, '0, '0, '0, '0});
    vecs.push_back('{'0, '0, '0, '0, '0, 32'hFFFF_FFFF, '0, '1, '1, '1, 32'h1C00_0002, 32'h0340_0000, '1, 8'h08});
    vecs.push_back('{'0, '0, '0, '0, '0, '0, '0, '1, '0, '1, '0, '0, '0, '0});
    vecs.push_back('{'1, '1, '0, 32'h1C00_0040, '0, '0, '0, '1, '0, '1, '0, '0, '0, '0});
    vecs.push_back('{'0, '0, '0, '0, '0, 32'h1111_1111, '0, '0, '1, '0, 32'h1C00_0040, 32'h1111_1111, '0, '0});
    vecs.push_back('{'0, '0, '0, '0, '0, 32'h2222_2222, '0, '0, '1, '0, 32'h1C00_0040, 32'h1111_1111, '0, '0});
    vecs.push_back('{'1, '1, '0, 32'h1C00_0100, '0, 32'h3333_3333, '1, '0, '0, '1, '0, '0, '0, '0});
    vecs.push_back('{'0, '0, '0, '0, '0, 32'h4444_4444, '0, '1, '1, '1, 32'h1C00_0100, 32'h4444_4444, '0, '0});
    vecs.push_back('{'0, '0, '0, '0, '0, '0, '0, '1, '0, '1, '0, '0, '0, '0});
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 0, 74'(pDD_valid), 74'(0));
    chk("rst_allowin", 0, 74'(pD_allowin), 74'(1));
    chk("rst_bus", 0, pDD_BUS, 74'(0));
    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].fv, vecs[i].pe, vecs[i].ex, vecs[i].pc, vecs[i].ecode, vecs[i].rdata, vecs[i].fl, vecs[i].dal);
      #1;
      chk("valid", i, 74'(pDD_valid), 74'(vecs[i].ev));
      chk("allowin", i, 74'(pD_allowin), 74'(vecs[i].ea));
      if (vecs[i].ev) chk("bus", i, pDD_BUS, {vecs[i].epc, vecs[i].einst, vecs[i].eex, vecs[i].eecode, 1'b0});
    end
    @(negedge clk);
    drive(1, 1, 0, 32'h1C00_0200, 0, 0, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 32'h7777_7777, 0, 0);
    #1;
    chk("ar_pre_valid", 0, 74'(pDD_valid), 74'(1));
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("ar_pre_bus", 0, pDD_BUS, {32'h1C00_0200, 32'h7777_7777, 10'h0});
    #1 rst = 1'b1;
    #1;
    chk("ar_valid", 0, 74'(pDD_valid), 74'(0));
    chk("ar_allowin", 0, 74'(pD_allowin), 74'(1));
    chk("ar_bus", 0, pDD_BUS, 74'(0));
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 0, 32'h1C00_0300, 0, 32'h9999_9999, 0, 0);
    #1;
    chk("ar_post_valid", 0, 74'(pDD_valid), 74'(0));
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 32'h8888_8888, 0, 0);
    #1;
    chk("ar_new_bus", 0, pDD_BUS, {32'h1C00_0300, 32'h8888_8888, 10'h0});
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 32'h0, 0, 1);
    #1;
    chk("ar_new_hold", 0, pDD_BUS, {32'h1C00_0300, 32'h8888_8888, 10'h0});
    for (int n = 0; n < 400; n++)
      rcycle(n, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
    for (int n = 0; n < 4; n++) rcycle(400 + n, 0, 0, 0, 1);
    chk("sb_drained", 0, 74'(sb.size()), 74'(0));
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/pre_decode.md
# pre_decode

Pre-decode (pD) pipeline stage between Fetch and Decode. Accepts the per-cycle fetch bundle on the FpD bus, pairs it with the synchronous instruction-SRAM read data that returns one cycle after the request, and forwards a {pc, inst, exception} bundle to Decode. Contains a one-entry instruction skid buffer so SRAM read data is never lost while Decode stalls. Drives the `pD_allowin` back-pressure signal consumed by Fetch.

## Interface
Parameters:
- `NOP_INST`, 32'h0340_0000, instruction word substituted when the bundle carries a fetch exception.

Ports (reset is asynchronous, active-high):
- `clk`  in  1  stage clock
- `rst`  in  1  asynchronous active-high reset
- `FpD_valid`  in  1  Fetch bundle valid
- `FpD_BUS`  in  `FpD_BUS_Wid` (43)  {pc[31:0] 42:11, pc_en 10, ex 9, ecode[7:0] 8:1, esubcode 0}
- `inst_sram_rdata`  in  32  SRAM read data for the request issued in the previous cycle
- `flush`  in  1  pipeline redirect (branch taken, exception entry, ertn) from later stages
- `D_allowin`  in  1  Decode can accept a bundle this cycle
- `pD_allowin`  out  1  pD can accept a Fetch bundle this cycle
- `pDD_valid`  out  1  bundle to Decode valid
- `pDD_BUS`  out  `pDD_BUS_Wid` (74)  {pc[31:0] 73:42, inst[31:0] 41:10, ex 9, ecode[7:0] 8:1, esubcode 0}

## Operation
- State: `pD_valid`, `pc_q`, `ex_q`, `ecode_q`, `esub_q`, `inst_buf[31:0]`, `buf_valid`, `first_q` (stage loaded last cycle, so SRAM data is on `inst_sram_rdata` now).
- Accept condition: `accept = FpD_valid && pc_en && pD_allowin`. Bundles with `pc_en = 0` carry no SRAM request and are ignored.
- `pD_allowin = !pD_valid || D_allowin || flush`.
- On accept: `pD_valid <= 1`, latch pc/ex/ecode/esubcode, `first_q <= 1`, `buf_valid <= 0`.
- Leave without replacement: `pD_valid <= 0` when `D_allowin && !accept`.
- Instruction selection: `inst = ex_q ? NOP_INST : (buf_valid ? inst_buf : inst_sram_rdata)`.
- Skid capture: when `first_q && pD_valid && !D_allowin && !flush`, `inst_buf <= inst_sram_rdata`, `buf_valid <= 1`. `first_q` clears on any cycle without accept.
- `pDD_valid = pD_valid && !flush`. `pDD_BUS` is assembled combinationally from held state and the selected inst.
- Flush: held bundle and `buf_valid` are discarded, and `pDD_valid` is 0 in that cycle. A Fetch bundle presented in the same cycle is the redirected fetch. It is accepted normally, because `pD_allowin` is forced to 1 by flush.
- Exception bundles (`ex = 1`) flow through like normal bundles. SRAM data is ignored for them.

## Timing
- Reset values: `pD_valid = 0`, `buf_valid = 0`, `first_q = 0`, all payload registers 0. Outputs are `pDD_valid = 0`, `pD_allowin = 1`, `pDD_BUS = 0` (inst field = `NOP_INST` is not applied because `ex_q = 0`; the inst field shows `inst_sram_rdata` but is don't-care while invalid).
- Latency: a bundle accepted at edge N is presented to Decode in cycle N+1, with inst taken directly from `inst_sram_rdata`.
- Throughput: 1 bundle/cycle when `D_allowin` is held high.
- Stall of k cycles: the bundle is held and the inst comes from `inst_buf` from cycle N+2 onward. Output is stable until `D_allowin`.
- Simultaneous accept and leave: the new bundle replaces the old bundle at the same edge, with no bubble.
- Reset asserted mid-stall clears all state asynchronously. The SRAM response in flight is ignored.

## Structure
- `FpD_BUS_Wid` (43), `pDD_BUS_Wid` (74) and `NOP_INST` constant go in the shared `Defines.vh`. The ecode/esubcode field widths are also shared there.
- One natural sub-module: `inst_skid_buf` (32-bit one-entry buffer with capture/clear/valid).

## Test plan
- Streaming: pc 0x1C00_0000, +4, +8 with `D_allowin = 1` and rdata 0xA, 0xB, 0xC on successive cycles -> Decode sees (0x1C00_0000, 0xA), (…04, 0xB), (…08, 0xC) on consecutive cycles.
- Stall: accept pc 0x1C00_0010 with rdata 0x1234_5678, hold `D_allowin = 0` for 3 cycles while rdata changes to 0xDEAD_BEEF -> the output inst stays 0x1234_5678 and `pD_allowin = 0` until release.
- `pc_en = 0` bundle while empty -> `pDD_valid` stays 0 and no state change.
- Fetch exception: `ex = 1`, ecode = ADEF, pc 0x1C00_0002 -> Decode receives inst 0x0340_0000 with ex = 1 and ecode = ADEF.
- Flush during stall, with new bundle pc 0x1C00_0100 in the same cycle -> `pDD_valid = 0` that cycle. The next cycle shows pc 0x1C00_0100 with the new rdata, and `buf_valid` is 0.
- Async reset asserted mid-stall -> `pDD_valid` drops to 0 immediately and `pD_allowin = 1`.
